// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: the decoded control bundle carried from ID into EX.
package mips_pkg;

  localparam int         CTRL_W   = 9;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded instruction in, registered EX view and fetch enables out.
interface id_ex_stage_if #(parameter int DATA_W = 32);
  import mips_pkg::*;

  logic              id_valid;
  ctrl_t             id_ctrl;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic              flush;
  logic              hold;

  logic              ex_valid;
  ctrl_t             ex_ctrl;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;
  logic              pc_write;
  logic              if_id_write;

  modport master (
    output id_valid, id_ctrl, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, flush, hold,
    input  ex_valid, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
           pc_write, if_id_write
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, flush, hold,
    output ex_valid, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
           pc_write, if_id_write
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination is read by the instruction in ID.
// Purely combinational; both source indices are checked whatever the instruction format.
module hazard_detect
  import mips_pkg::*;
(
  input  logic       id_valid,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       lu
);

  always_comb begin
    lu = id_valid & ex_valid & ex_mem_read & (ex_rt != REG_ZERO)
       & ((ex_rt == id_rs) | (ex_rt == id_rt));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register, one-cycle latency; hold freezes it, flush/load-use insert a bubble.
// HAZARD_STATS_EN adds saturating stall_cnt/flush_cnt outputs.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
`endif
);

  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic [4:0]        rd_q, rd_d;
  logic              flush_pending_q, flush_pending_d;
  logic              lu;
  logic              flush_eff;
  logic              fetch_en;

  hazard_detect u_hazard_detect (
    .id_valid    (bus.id_valid),
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rt       (rt_q),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .lu          (lu)
  );

  assign flush_eff = bus.flush | flush_pending_q;

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    fetch_en  = 1'b1;

    if (bus.hold) begin
      fetch_en = 1'b0;
    end else if (flush_eff || lu) begin
      // A flush wins over load-use, so fetch keeps moving to the redirect target.
      valid_d   = 1'b0;
      ctrl_d    = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      fetch_en  = flush_eff;
    end else begin
      valid_d   = bus.id_valid;
      ctrl_d    = bus.id_ctrl;
      rs_data_d = bus.id_rs_data;
      rt_data_d = bus.id_rt_data;
      imm_d     = bus.id_imm;
      rs_d      = bus.id_rs;
      rt_d      = bus.id_rt;
      rd_d      = bus.id_rd;
    end

    if (rst) begin
      fetch_en = 1'b1;
    end

    flush_pending_d = bus.hold ? (flush_pending_q | bus.flush) : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q         <= 1'b0;
      ctrl_q          <= '0;
      rs_data_q       <= '0;
      rt_data_q       <= '0;
      imm_q           <= '0;
      rs_q            <= '0;
      rt_q            <= '0;
      rd_q            <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      ctrl_q          <= ctrl_d;
      rs_data_q       <= rs_data_d;
      rt_data_q       <= rt_data_d;
      imm_q           <= imm_d;
      rs_q            <= rs_d;
      rt_q            <= rt_d;
      rd_q            <= rd_d;
      flush_pending_q <= flush_pending_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.hold && flush_eff && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
    if (!bus.hold && !flush_eff && lu && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

  assign bus.ex_valid    = valid_q;
  assign bus.ex_ctrl     = ctrl_q;
  assign bus.ex_rs_data  = rs_data_q;
  assign bus.ex_rt_data  = rt_data_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_rs       = rs_q;
  assign bus.ex_rt       = rt_q;
  assign bus.ex_rd       = rd_q;
  assign bus.pc_write    = fetch_en;
  assign bus.if_id_write = fetch_en;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load-use stalls, flush priority, hold with pending flush, reset.
// Counter checks are compiled only when HAZARD_STATS_EN is defined.
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam ctrl_t C_LW  = 9'b111001000;
  localparam ctrl_t C_ADD = 9'b100000110;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  id_ex_stage_if #(.DATA_W(32)) bus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] fc0;
  logic [31:0] sc0;
`endif

  id_ex_stage #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input ctrl_t c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm);
    bus.id_valid   = v;
    bus.id_ctrl    = c;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_rd      = rd;
    bus.id_rs_data = a;
    bus.id_rt_data = b;
    bus.id_imm     = imm;
  endtask

  initial begin
    rst       = 1'b1;
    bus.hold  = 1'b1;
    bus.flush = 1'b0;
    drive(1'b1, C_LW, 5'd1, 5'd2, 5'd3, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0000_0010);

    // reset with hold asserted
    tick();
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_ctrl", bus.ex_ctrl, 0);
    chk("rst_rs_data", bus.ex_rs_data, 0);
    chk("rst_rt", bus.ex_rt, 0);
    chk("rst_pc_write", bus.pc_write, 1);
    chk("rst_if_id_write", bus.if_id_write, 1);
`ifdef HAZARD_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
`endif

    // lw $8 enters EX
    rst      = 1'b0;
    bus.hold = 1'b0;
    drive(1'b1, C_LW, 5'd9, 5'd8, 5'd0, 32'h0000_1000, 32'h0000_2000, 32'h0000_0004);
    #1;
    chk("lw_pc_write_pre", bus.pc_write, 1);
    tick();
    chk("lw_cap_valid", bus.ex_valid, 1);
    chk("lw_cap_ctrl", bus.ex_ctrl, C_LW);
    chk("lw_cap_rt", bus.ex_rt, 8);
    chk("lw_cap_rs_data", bus.ex_rs_data, 32'h0000_1000);
    chk("lw_cap_imm", bus.ex_imm, 32'h0000_0004);

    // dependent add: stall, bubble, then capture
    drive(1'b1, C_ADD, 5'd8, 5'd10, 5'd11, 32'h0000_0111, 32'h0000_0222, 32'h0);
    #1;
    chk("lu_pc_write", bus.pc_write, 0);
    chk("lu_if_id_write", bus.if_id_write, 0);
    tick();
    chk("lu_bubble_valid", bus.ex_valid, 0);
    chk("lu_bubble_ctrl", bus.ex_ctrl, 0);
    chk("lu_bubble_rt", bus.ex_rt, 0);
    chk("lu_bubble_rs_data", bus.ex_rs_data, 0);
    chk("lu_cleared_pc_write", bus.pc_write, 1);
`ifdef HAZARD_STATS_EN
    chk("lu_stall_cnt", stall_cnt, 1);
`endif
    tick();
    chk("add_cap_valid", bus.ex_valid, 1);
    chk("add_cap_rd", bus.ex_rd, 11);
    chk("add_cap_ctrl", bus.ex_ctrl, C_ADD);
    chk("add_cap_rt_data", bus.ex_rt_data, 32'h0000_0222);

    // load to $0 never stalls
    drive(1'b1, C_LW, 5'd0, 5'd0, 5'd0, 32'h5, 32'h6, 32'h7);
    tick();
    drive(1'b1, C_ADD, 5'd0, 5'd0, 5'd12, 32'h8, 32'h9, 32'h0);
    #1;
    chk("r0_pc_write", bus.pc_write, 1);
    tick();
    chk("r0_cap_valid", bus.ex_valid, 1);
    chk("r0_cap_rd", bus.ex_rd, 12);

    // lw $8 in EX, then an invalid ID slot, then flush with load-use
    drive(1'b1, C_LW, 5'd2, 5'd8, 5'd0, 32'h11, 32'h22, 32'h33);
    tick();
    drive(1'b0, C_ADD, 5'd8, 5'd10, 5'd14, 32'h44, 32'h55, 32'h0);
    #1;
    chk("idinv_pc_write", bus.pc_write, 1);
    bus.id_valid = 1'b1;
    #1;
    chk("lu_again_pc_write", bus.pc_write, 0);
    bus.flush = 1'b1;
`ifdef HAZARD_STATS_EN
    sc0 = stall_cnt;
    fc0 = flush_cnt;
`endif
    #1;
    chk("flush_lu_pc_write", bus.pc_write, 1);
    tick();
    chk("flush_bubble_valid", bus.ex_valid, 0);
    chk("flush_bubble_ctrl", bus.ex_ctrl, 0);
`ifdef HAZARD_STATS_EN
    chk("flush_stall_cnt", stall_cnt, sc0);
    chk("flush_flush_cnt", flush_cnt, fc0 + 32'd1);
`endif
    bus.flush = 1'b0;

    // hold for three edges with flush pulsed on the second
    drive(1'b1, C_ADD, 5'd3, 5'd4, 5'd5, 32'h0000_0033, 32'h0000_0044, 32'h0);
    tick();
    chk("a_cap_rd", bus.ex_rd, 5);
    bus.hold = 1'b1;
    drive(1'b1, C_ADD, 5'd6, 5'd7, 5'd13, 32'h0000_0066, 32'h0000_0077, 32'h0);
    #1;
    chk("hold_pc_write", bus.pc_write, 0);
    chk("hold_if_id_write", bus.if_id_write, 0);
`ifdef HAZARD_STATS_EN
    fc0 = flush_cnt;
`endif
    tick();
    chk("hold1_rd", bus.ex_rd, 5);
    chk("hold1_rs_data", bus.ex_rs_data, 32'h0000_0033);
    bus.flush = 1'b1;
    tick();
    chk("hold2_rd", bus.ex_rd, 5);
    bus.flush = 1'b0;
    tick();
    chk("hold3_rd", bus.ex_rd, 5);
    chk("hold3_valid", bus.ex_valid, 1);
    bus.hold = 1'b0;
    #1;
    chk("pend_pc_write", bus.pc_write, 1);
    tick();
    chk("pend_bubble_valid", bus.ex_valid, 0);
    chk("pend_bubble_rd", bus.ex_rd, 0);
`ifdef HAZARD_STATS_EN
    chk("pend_flush_cnt", flush_cnt, fc0 + 32'd1);
`endif
    tick();
    chk("b_cap_valid", bus.ex_valid, 1);
    chk("b_cap_rd", bus.ex_rd, 13);

    // reset overrides hold and flush
    rst       = 1'b1;
    bus.hold  = 1'b1;
    bus.flush = 1'b1;
    tick();
    chk("rst2_valid", bus.ex_valid, 0);
    chk("rst2_rd", bus.ex_rd, 0);
    chk("rst2_ctrl", bus.ex_ctrl, 0);
    chk("rst2_rs_data", bus.ex_rs_data, 0);
    chk("rst2_pc_write", bus.pc_write, 1);
`ifdef HAZARD_STATS_EN
    chk("rst2_stall_cnt", stall_cnt, 0);
    chk("rst2_flush_cnt", flush_cnt, 0);
`endif
    rst       = 1'b0;
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    tick();
    chk("post_rst_valid", bus.ex_valid, 1);
    chk("post_rst_rd", bus.ex_rd, 13);

`ifdef HAZARD_STATS_EN
    // saturation of the stall counter
    drive(1'b1, C_LW, 5'd2, 5'd8, 5'd0, 32'h1, 32'h2, 32'h3);
    tick();
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    drive(1'b1, C_ADD, 5'd8, 5'd9, 5'd15, 32'h4, 32'h5, 32'h0);
    tick();
    chk("sat_bubble_valid", bus.ex_valid, 0);
    chk("sat_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of the operand, immediate and data fields.
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 id_valid  in  1  IF/ID holds a real instruction.
REQ-005 id_ctrl  in  CTRL_W(9)  packed {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, RegDst, ALUOp[1:0]}.
REQ-006 id_rs_data, id_rt_data, id_imm  in  DATA_W  register-file reads and sign-extended immediate.
REQ-007 id_rs, id_rt, id_rd  in  5  decoded register indices.
REQ-008 flush  in  1  taken branch/jump; kill the instruction currently in ID.
REQ-009 hold  in  1  downstream stall (memory busy); freeze ID/EX.
REQ-010 ex_valid, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd  out  as inputs  registered ID/EX contents; ex_rs/ex_rt feed the forwarding unit.
REQ-011 pc_write, if_id_write  out  1  combinational enables for PC and IF/ID; 0 means hold.

Function
REQ-012 Load-use hazard (lu) SHALL be id_valid & ex_valid & ex_ctrl.MemRead & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt); both indices compared regardless of instruction format.
REQ-013 Edge action priority SHALL be: rst > hold > flush (or pending flush) > lu > normal capture.
REQ-014 Normal capture: all ex_* fields load id_* with ex_valid=id_valid; latency one cycle.
REQ-015 Bubble (flush or lu): ex_valid=0, ex_ctrl=0, ex_rs=ex_rt=ex_rd=0, data fields 0.
REQ-016 hold: all ex_* registers keep their value; pc_write=if_id_write=0.
REQ-017 lu with hold=0 and no flush: pc_write=if_id_write=0 same cycle; bubble inserted next edge; lu SHALL clear after exactly one bubble.
REQ-018 flush (or pending flush) with hold=0: bubble inserted, pc_write=if_id_write=1 even if lu true.
REQ-019 flush asserted while hold=1 SHALL set a flush_pending flag; the first edge with hold=0 inserts the bubble and clears it; repeated flush during hold keeps one pending flush.
REQ-020 Otherwise pc_write=if_id_write=1.

Reset
REQ-021 On rst edge: all ex_* outputs 0, flush_pending 0, counters 0; rst overrides hold and flush.
REQ-022 While rst=1, pc_write=if_id_write=1 (combinational, no hazard since ex_valid=0 after first edge).

Configuration
REQ-023 With HAZARD_STATS_EN defined: outputs stall_cnt, flush_cnt (32 bits each); stall_cnt +1 per lu bubble, flush_cnt +1 per flush bubble; both saturate at 32'hFFFF_FFFF; frozen during hold.
REQ-024 Without HAZARD_STATS_EN: those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-025 Package mips_pkg SHALL hold the ctrl_t packed struct, CTRL_W, and REG_ZERO constant.
REQ-026 Load-use compare SHALL live in sub-module hazard_detect (pure combinational); pipeline register and flush_pending in id_ex_stage.

Verification
REQ-027 lw $8 in EX (MemRead, ex_rt=8), add using rs=8 in ID -> pc_write=0 that cycle; next edge ex_valid=0, ex_ctrl=0; following edge add captured.
REQ-028 lw with ex_rt=0 and id_rs=0 -> no stall, pc_write=1.
REQ-029 flush=1 with lu true simultaneously -> bubble, pc_write=1, stall_cnt unchanged, flush_cnt +1 (macro on).
REQ-030 hold=1 for 3 cycles with flush pulsed in cycle 2 -> ex_* frozen 3 cycles; first edge after hold drops gives bubble; then normal capture.
REQ-031 rst=1 with hold=1 and ex_valid=1 -> next edge all ex_* 0, counters 0.
REQ-032 Force stall_cnt to 32'hFFFF_FFFF, trigger lu -> stays 32'hFFFF_FFFF.
